regfile_wr_arbiter: RTL

- Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Round-robin arbitration with a valid/ready handshake, registered drive of the write port, and X31 (XZR) write suppression.
- Keeps a pending-write scoreboard so the decode stage can flag read-after-write hazards on the two asynchronous read ports.
- Sits between the writeback stage and the 32x64 register file.

---
 rtl/regfile_wr_arbiter_pkg.sv | 23 ++
 rtl/regfile_wr_arbiter_rr_arb2.sv | 41 ++++
 rtl/regfile_wr_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and payload types for the register-file write-port arbiter.
package regfile_pkg;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NREG     = 32;
   localparam int unsigned ZERO_REG = 31;

   typedef logic [ADDR_W-1:0] reg_idx_t;

   typedef struct packed {
      logic              valid;
      reg_idx_t          addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   // Which requester wins the next contended cycle.
   typedef enum logic {
      PTR_REQ0 = 1'b0,
      PTR_REQ1 = 1'b1
   } arb_ptr_e;

endpackage : regfile_pkg

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant with a priority pointer that only moves on contention.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       hold_i,
   output logic [1:0] gnt_o
);

   arb_ptr_e ptr_q, ptr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= PTR_REQ0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Grants are suppressed during reset so ready reads low while reset is held.
   always_comb begin
      ptr_d = ptr_q;
      gnt_o = 2'b00;
      if (!reset && !hold_i) begin
         if (req_i == 2'b11) begin
            if (ptr_q == PTR_REQ0) begin
               gnt_o = 2'b01;
               ptr_d = PTR_REQ1;
            end else begin
               gnt_o = 2'b10;
               ptr_d = PTR_REQ0;
            end
         end else begin
            gnt_o = req_i;
         end
      end
   end

endmodule : rr_arb2

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a
// pending-write scoreboard that flags read-after-write hazards for decode.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              wr_stall,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              rd1_hazard,
   output logic              rd2_hazard
);

   localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

   wr_req_t           req0_s, req1_s, win_s;
   logic [1:0]        gnt;
   logic              win_fire;
   logic              win_real;

   logic              we3_q, we3_d;
   reg_idx_t          wa3_q, wa3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   logic [NREG-1:0]   pending_q, pending_d;

   assign req0_s = '{valid: req0_valid, addr: req0_addr, data: req0_data};
   assign req1_s = '{valid: req1_valid, addr: req1_addr, data: req1_data};

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req_i  ({req1_valid, req0_valid}),
      .hold_i (wr_stall),
      .gnt_o  (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   assign win_s    = gnt[1] ? req1_s : req0_s;
   assign win_fire = (|gnt) & win_s.valid;
   assign win_real = win_fire & (win_s.addr != ZERO_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we3_q     <= 1'b0;
         wa3_q     <= '0;
         wd3_q     <= '0;
         pending_q <= '0;
      end else begin
         we3_q     <= we3_d;
         wa3_q     <= wa3_d;
         wd3_q     <= wd3_d;
         pending_q <= pending_d;
      end
   end

   // Write-port register: capture on grant, hold everything through a stall.
   always_comb begin
      we3_d = 1'b0;
      wa3_d = wa3_q;
      wd3_d = wd3_q;
      if (wr_stall) begin
         we3_d = we3_q;
      end else if (win_fire) begin
         we3_d = win_real;
         wa3_d = win_s.addr;
         wd3_d = win_s.data;
      end
   end

   // Clear applied before set so a back-to-back write to one register stays pending.
   always_comb begin
      pending_d = pending_q;
      if (we3_q && !wr_stall) begin
         pending_d[wa3_q] = 1'b0;
      end
      if (win_real) begin
         pending_d[win_s.addr] = 1'b1;
      end
   end

   assign we3        = we3_q;
   assign wa3        = wa3_q;
   assign wd3        = wd3_q;
   assign rd1_hazard = pending_q[ra1] & (ra1 != ZERO_IDX);
   assign rd2_hazard = pending_q[ra2] & (ra2 != ZERO_IDX);

endmodule : regfile_wr_arbiter
